// File: rtl/risc_pkg.sv
// Shared fetch-path types and constants: instruction width, halt encoding and queue entry layout.
package risc_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    localparam logic [INST_W-1:0] HALT_INST = '1;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue bus: control inputs, instruction-memory port, decode-side output and halt status.
interface fetch_queue_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              fetch_en;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              halted;

    modport master (
        input  fetch_en, redirect, redirect_pc, imem_data, out_ready,
        output imem_req, imem_addr, out_valid, out_inst, out_pc, halted
    );

    modport slave (
        output fetch_en, redirect, redirect_pc, imem_data, out_ready,
        input  imem_req, imem_addr, out_valid, out_inst, out_pc, halted
    );
endinterface

// File: rtl/fetch_fifo.sv
// Circular FIFO holding {pc, inst} fetch entries; flush empties it and wins over push/pop.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            // Simultaneous push and pop keeps the count, even when full.
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-based issue to a 1-cycle memory, redirect flush, in-order delivery.
// Optional halt detection is enabled by defining FETCH_QUEUE_HALT_DETECT_EN.
module fetch_queue
    import risc_pkg::*;
#(
    parameter int                DATA_W   = INST_W,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_queue_if.master bus
);
    localparam int                CNT_W   = $clog2(DEPTH) + 1;
    localparam int                ENTRY_W = ADDR_W + DATA_W;
    localparam logic [CNT_W:0]    DEPTH_C = (CNT_W+1)'(DEPTH);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic               inflight_q, inflight_d;
    logic [CNT_W-1:0]   count;
    logic [CNT_W:0]     credit;
    logic [ENTRY_W-1:0] head;
    logic               push, pop, issue, halt_block;

    assign pop    = bus.out_valid & bus.out_ready;
    assign push   = inflight_q & ~bus.redirect;
    // Entries already held plus the one still coming back, less what leaves this cycle.
    assign credit = {1'b0, count} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
    assign issue  = rst_n & bus.fetch_en & ~bus.redirect & ~halt_block & (credit < DEPTH_C);

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = (count != '0);
    assign {bus.out_pc, bus.out_inst} = head;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
        if (bus.redirect) begin
            fetch_pc_d = bus.redirect_pc;
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect),
        .wdata ({inflight_pc_q, bus.imem_data}),
        .rdata (head),
        .count (count)
    );

`ifdef FETCH_QUEUE_HALT_DETECT_EN
    logic halt_pending_q, halt_pending_d, halted_q, halted_d;

    // Halt word stops issue once it lands; it only reports halted when decode takes it.
    always_comb begin
        halt_pending_d = halt_pending_q;
        halted_d       = halted_q;
        if (bus.redirect) begin
            halt_pending_d = 1'b0;
            halted_d       = 1'b0;
        end else begin
            if (push && (&bus.imem_data)) halt_pending_d = 1'b1;
            if (pop && (&bus.out_inst))   halted_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_pending_q <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            halt_pending_q <= halt_pending_d;
            halted_q       <= halted_d;
        end
    end

    assign halt_block = halt_pending_q;
    assign bus.halted = halted_q;
`else
    assign halt_block = 1'b0;
    assign bus.halted = 1'b0;
`endif

endmodule
